// File: rtl/phase_corr_sched.sv
// phase_corr_sched: one time-multiplexed saturating two-tap sum unit,
// y[n] = x[n] + x[n-2], shared round-robin by two sample channels
// (ch0 = I, ch1 = Q), with a tagged, registered output stream.
// Build option: define PHASE_CORR_SAT_EN to clamp overflowing sums and
// report clamps on o_sat; when undefined the sum wraps and o_sat is 0.
//
// Handshake: an input sample on channel k transfers on a rising edge where
// i_validk=1 and o_readyk=1; o_readyk is the combinational grant and is
// never high for both channels at once. The output transfers on a rising
// edge where o_valid=1 and i_ready=1; while o_valid=1 and i_ready=0 the
// output register holds and no channel is granted.

module phase_corr_sched #(
    parameter int NB_DATA = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_data0,
    input  logic               i_valid0,
    output logic               o_ready0,
    input  logic [NB_DATA-1:0] i_data1,
    input  logic               i_valid1,
    output logic               o_ready1,
    input  logic               i_clear,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_ch,
    output logic               o_sat,
    output logic               o_valid,
    input  logic               i_ready
);

    // Per-channel history: h1 = x[n-1], h2 = x[n-2]
    logic [NB_DATA-1:0] r_h1_0;
    logic [NB_DATA-1:0] r_h2_0;
    logic [NB_DATA-1:0] r_h1_1;
    logic [NB_DATA-1:0] r_h2_1;
    // Last granted channel; reset to 1 so ch0 wins the first contention
    logic               r_last;
    // Output register
    logic [NB_DATA-1:0] r_data;
    logic               r_ch;
    logic               r_sat;
    logic               r_valid;

    logic               w_can_issue;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_grant;
    logic               w_sel;
    logic [NB_DATA-1:0] w_x;
    logic [NB_DATA-1:0] w_h2;
    logic [NB_DATA-1:0] w_res;
    logic               w_sat;

    // The unit can accept a new sample when the output slot is free or
    // is being drained this cycle; grants are masked during reset.
    assign w_can_issue = !r_valid || i_ready;
    assign w_gnt0 = i_rst_n && w_can_issue && i_valid0 && (!i_valid1 || r_last);
    assign w_gnt1 = i_rst_n && w_can_issue && i_valid1 && (!i_valid0 || !r_last);
    assign w_grant = w_gnt0 || w_gnt1;
    assign w_sel   = w_gnt1;

    // Operand mux: a same-cycle clear makes the granted sample see h2 = 0
    assign w_x  = w_sel ? i_data1 : i_data0;
    assign w_h2 = i_clear ? '0 : (w_sel ? r_h2_1 : r_h2_0);

`ifdef PHASE_CORR_SAT_EN
    logic [NB_DATA:0] w_sum;

    assign w_sum = {w_x[NB_DATA-1], w_x} + {w_h2[NB_DATA-1], w_h2};

    // Overflow shows up as disagreement between the two top bits of the
    // one-bit-wider sum; the top bit then gives the direction of the clamp.
    always_comb begin
        w_res = w_sum[NB_DATA-1:0];
        w_sat = 1'b0;
        if (w_sum[NB_DATA] != w_sum[NB_DATA-1]) begin
            w_sat = 1'b1;
            w_res = w_sum[NB_DATA] ? {1'b1, {(NB_DATA-1){1'b0}}}
                                   : {1'b0, {(NB_DATA-1){1'b1}}};
        end
    end
`else
    // Wrap-around: the low NB_DATA bits of the sum are the result
    assign w_res = w_x + w_h2;
    assign w_sat = 1'b0;
`endif

    assign o_ready0 = w_gnt0;
    assign o_ready1 = w_gnt1;
    assign o_data   = r_data;
    assign o_ch     = r_ch;
    assign o_sat    = r_sat;
    assign o_valid  = r_valid;

    // History shift for the granted channel; clear zeroes both channels
    // before the granted sample lands in h1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h1_0 <= '0;
            r_h2_0 <= '0;
            r_h1_1 <= '0;
            r_h2_1 <= '0;
        end else if (i_clear) begin
            r_h1_0 <= w_gnt0 ? i_data0 : '0;
            r_h2_0 <= '0;
            r_h1_1 <= w_gnt1 ? i_data1 : '0;
            r_h2_1 <= '0;
        end else begin
            if (w_gnt0) begin
                r_h2_0 <= r_h1_0;
                r_h1_0 <= i_data0;
            end
            if (w_gnt1) begin
                r_h2_1 <= r_h1_1;
                r_h1_1 <= i_data1;
            end
        end
    end

    // Round-robin pointer follows the most recent grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_sel;
        end
    end

    // Output register: load on grant, drop valid when drained with no new
    // grant, hold everything under backpressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_ch    <= 1'b0;
            r_sat   <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_grant) begin
            r_data  <= w_res;
            r_ch    <= w_sel;
            r_sat   <= w_sat;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
